// File: rtl/fm_pkg.sv
// Shared FM link definitions: NCO word width, default gate length
// and demodulator FSM encoding, common to transmitter and receiver.
package fm_pkg;

    localparam int NCO_W         = 32;
    localparam int GATE_LOG2_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } fm_state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for the asynchronous carrier input,
// followed by a rising-edge detector on the synchronized level.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // shift the carrier through the synchronizer and keep the last level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_sig};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign o_level = sync[SYNC_STAGES-1];
    assign o_rise  = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/fm_demod_rx.sv
// Gated-count FM demodulator: counts carrier rising edges per gate
// window and converts the count into an NCO phase-increment estimate.
module fm_demod_rx
    import fm_pkg::*;
#(
    parameter int GATE_LOG2   = GATE_LOG2_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_MIN    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sig,
    input  logic [NCO_W-1:0] i_center,
    output logic [NCO_W-1:0] o_word,
    output logic [NCO_W-1:0] o_dev,
    output logic             o_valid,
    output logic             o_lock
);

    localparam logic [NCO_W-1:0] LOCK_W = NCO_W'(LOCK_MIN);

    fm_state_t            state;
    logic [GATE_LOG2-1:0] gate_cnt;
    logic [GATE_LOG2-1:0] edge_cnt;
    logic [GATE_LOG2-1:0] edge_sum;
    logic [NCO_W-1:0]     win_cnt;
    logic [NCO_W-1:0]     word_new;
    logic                 terminal;
    logic                 rise;
    logic                 level_unused;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sig  (i_sig),
        .o_level(level_unused),
        .o_rise (rise)
    );

    // window edge total including an edge on the current cycle, saturating
    always_comb begin
        terminal = &gate_cnt;
        edge_sum = edge_cnt;
        if (!(&edge_cnt) && rise) begin
            edge_sum = edge_cnt + GATE_LOG2'(1);
        end
        win_cnt  = NCO_W'(edge_sum);
        word_new = win_cnt << (NCO_W - GATE_LOG2);
    end

    // gate FSM, counters and registered window results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            o_word   <= '0;
            o_dev    <= '0;
            o_valid  <= 1'b0;
            o_lock   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (!i_en) begin
                state    <= ST_IDLE;
                gate_cnt <= '0;
                edge_cnt <= '0;
                o_lock   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state    <= ST_SETTLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end
                    ST_SETTLE, ST_MEASURE: begin
                        gate_cnt <= gate_cnt + GATE_LOG2'(1);
                        if (terminal) begin
                            edge_cnt <= '0;
                            state    <= ST_MEASURE;
                            if (state == ST_MEASURE) begin
                                o_word  <= word_new;
                                o_dev   <= word_new - i_center;
                                o_valid <= 1'b1;
                                o_lock  <= (win_cnt >= LOCK_W);
                            end
                        end else begin
                            edge_cnt <= edge_sum;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fm_demod_rx.sv
// Directed bench for fm_demod_rx: DDS carrier, stuck and toggling
// inputs, enable drop and mid-window reset, with immediate assertions.
module tb_fm_demod_rx;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_sig;
    logic [31:0] i_center;
    logic [31:0] o_word;
    logic [31:0] o_dev;
    logic        o_valid;
    logic        o_lock;

    int          checks;
    int          errors;
    int          cyc;
    int          vcnt;
    int          last_vcyc;
    int          prev_vcyc;
    int          mode;
    int          n;
    int          v0;
    logic [31:0] dds_word;
    logic [31:0] dds_acc;

    fm_demod_rx #(
        .GATE_LOG2  (12),
        .SYNC_STAGES(2),
        .LOCK_MIN   (1)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_sig   (i_sig),
        .i_center(i_center),
        .o_word  (o_word),
        .o_dev   (o_dev),
        .o_valid (o_valid),
        .o_lock  (o_lock)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp, input logic [31:0] tol);
        logic [31:0] d;
        d = obs - exp + tol;
        checks++;
        assert (d <= 2 * tol) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h +/- %h",
                   tag, obs, exp, tol);
        end
    endtask

    // one clock: sample after the edge, then drive the next carrier bit
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_valid === 1'b1) begin
            vcnt++;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
        end
        cyc++;
        case (mode)
            0: begin
                dds_acc = dds_acc + dds_word;
                i_sig   = dds_acc[31];
            end
            1: i_sig = 1'b0;
            default: i_sig = ~i_sig;
        endcase
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_valid(input int max_cyc, output int cnt);
        logic got;
        got = 1'b0;
        cnt = 0;
        while (cnt < max_cyc && !got) begin
            step();
            cnt++;
            got = (o_valid === 1'b1);
        end
        if (!got) cnt = -1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        vcnt      = 0;
        last_vcyc = 0;
        prev_vcyc = 0;
        mode      = 0;
        dds_word  = 32'h0100_0000;
        dds_acc   = 32'h0;
        i_rst_n   = 1'b0;
        i_en      = 1'b0;
        i_sig     = 1'b0;
        i_center  = 32'h0100_0000;

        steps(3);
        chk("rst_word", o_word, 32'h0);
        chk("rst_dev", o_dev, 32'h0);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_lock", {31'h0, o_lock}, 32'h0);
        i_rst_n = 1'b1;
        steps(2);

        // nominal carrier: 16 edges per 4096-cycle window
        i_en = 1'b1;
        wait_valid(10000, n);
        chk("first_latency", n, 32'd8193);
        chk_near("nom_word", o_word, 32'h0100_0000, 32'h0010_0000);
        chk_near("nom_dev", o_dev, 32'h0, 32'h0010_0000);
        chk("nom_word_exact", o_word, 32'h0100_0000);
        chk("nom_lock", {31'h0, o_lock}, 32'h1);
        step();
        chk("valid_one_cycle", {31'h0, o_valid}, 32'h0);

        // deviated carrier: 17 edges per window
        dds_word = 32'h0110_0000;
        wait_valid(5000, n);
        wait_valid(5000, n);
        chk("dev_wait", {31'h0, n > 0}, 32'h1);
        chk_near("dev_near", o_dev, 32'h0010_0000, 32'h0010_0000);
        chk("dev_exact", o_dev, 32'h0010_0000);
        chk("dev_word", o_word, 32'h0110_0000);
        chk("dev_period", last_vcyc - prev_vcyc, 32'd4096);

        // carrier stuck low
        mode = 1;
        wait_valid(5000, n);
        wait_valid(5000, n);
        chk("stuck_word", o_word, 32'h0);
        chk("stuck_dev", o_dev, 32'hFF00_0000);
        chk("stuck_lock", {31'h0, o_lock}, 32'h0);
        chk("stuck_period", last_vcyc - prev_vcyc, 32'd4096);

        // carrier toggling every clock: 2048 edges per window
        mode = 2;
        wait_valid(5000, n);
        wait_valid(5000, n);
        chk("tog_word", o_word, 32'h8000_0000);
        chk("tog_dev", o_dev, 32'h7F00_0000);
        chk("tog_lock", {31'h0, o_lock}, 32'h1);

        // new center only applies at the next window update
        i_center = 32'h0;
        step();
        chk("center_hold", o_dev, 32'h7F00_0000);
        wait_valid(5000, n);
        chk("center_apply", o_dev, 32'h8000_0000);
        i_center = 32'h0100_0000;

        // drop enable mid-window
        steps(1000);
        v0   = vcnt;
        i_en = 1'b0;
        step();
        chk("dis_lock", {31'h0, o_lock}, 32'h0);
        chk("dis_valid", {31'h0, o_valid}, 32'h0);
        chk("dis_word_hold", o_word, 32'h8000_0000);
        steps(5000);
        chk("dis_no_valid", vcnt - v0, 32'd0);
        chk("dis_dev_hold", o_dev, 32'h8000_0000);
        i_en = 1'b1;
        wait_valid(10000, n);
        chk("reen_latency", n, 32'd8193);
        chk("reen_word", o_word, 32'h8000_0000);

        // asynchronous reset mid-window
        steps(2000);
        i_rst_n = 1'b0;
        #1;
        chk("arst_word", o_word, 32'h0);
        chk("arst_dev", o_dev, 32'h0);
        chk("arst_lock", {31'h0, o_lock}, 32'h0);
        chk("arst_valid", {31'h0, o_valid}, 32'h0);
        steps(3);
        i_rst_n = 1'b1;
        wait_valid(10000, n);
        chk("post_rst_latency", n, 32'd8193);
        chk("post_rst_word", o_word, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_demod_rx.md
FM_DEMOD_RX -- requirements
Module: fm_demod_rx

Interface
REQ-001 SHALL have parameter GATE_LOG2, default 12, gate window length 2^GATE_LOG2 clocks, legal range 4..24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops, legal range 2..4.
REQ-003 SHALL have parameter LOCK_MIN, default 1, minimum rising edges per window to assert lock.
REQ-004 SHALL have port i_clk, input, 1, system clock.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_en, input, 1, measurement enable.
REQ-007 SHALL have port i_sig, input, 1, asynchronous 1-bit carrier from the DDS transmitter.
REQ-008 SHALL have port i_center, input, 32, nominal carrier phase-increment word.
REQ-009 SHALL have port o_word, output, 32, recovered phase-increment estimate.
REQ-010 SHALL have port o_dev, output, 32, signed deviation o_word minus i_center, two's complement.
REQ-011 SHALL have port o_valid, output, 1, one-cycle strobe marking new o_word/o_dev.
REQ-012 SHALL have port o_lock, output, 1, carrier present.

Function
REQ-013 SHALL pass i_sig through SYNC_STAGES flops; rising edge = synced & ~previous synced.
REQ-014 SHALL run FSM with states IDLE, SETTLE and MEASURE.
REQ-015 SHALL move IDLE->SETTLE when i_en=1, SETTLE->MEASURE at the end of the first window, and any state->IDLE when i_en=0, all transitions registered.
REQ-016 SHALL keep a GATE_LOG2-bit gate counter, cleared in IDLE, incrementing every cycle in SETTLE/MEASURE; terminal count is all-ones.
REQ-017 SHALL keep a GATE_LOG2-bit edge counter counting rising edges within the current window, saturating at all-ones.
REQ-018 An edge on the terminal-count cycle SHALL belong to the closing window; the edge counter SHALL restart at 0 on the next cycle.
REQ-019 At terminal count in MEASURE, the next cycle SHALL load o_word = edge_count << (32-GATE_LOG2), zero-filled and truncated to 32 bits.
REQ-020 That same cycle SHALL load o_dev = o_word_new - i_center (i_center sampled on the terminal cycle), wrapping modulo 2^32, and pulse o_valid for one cycle.
REQ-021 The window closing in SETTLE SHALL be discarded: no o_valid pulse and no output update.
REQ-022 o_lock SHALL be updated with o_valid: 1 if window edge_count >= LOCK_MIN, else 0.
REQ-023 With i_en=0, counters SHALL clear, o_valid=0 and o_lock=0 on the next cycle, and o_word/o_dev SHALL hold their values.
REQ-024 The first o_valid after i_en rises SHALL occur 2*2^GATE_LOG2+1 cycles after the first cycle i_en is sampled high.
REQ-025 i_center changes SHALL take effect only at the next window update.

Reset
REQ-026 Assertion of i_rst_n SHALL asynchronously clear all synchronizer flops, counters and outputs (o_word=0, o_dev=0, o_valid=0, o_lock=0) and set the FSM to IDLE.
REQ-027 Deassertion SHALL be taken synchronously; an active window interrupted by reset SHALL be discarded with no o_valid.

Structure
REQ-028 Shared package fm_pkg SHALL hold the NCO word width (32), the default GATE_LOG2 and the FSM state encoding, shared with the transmitter side.
REQ-029 Synchronizer plus edge detector SHALL be sub-module sig_sync_edge (params SYNC_STAGES; outputs synced level, rise pulse).

Verification
REQ-030 Drive from the transmitter DDS with word 0x0100_0000, i_center=0x0100_0000, GATE_LOG2=12 -> o_word=0x0100_0000 ±0x0010_0000, o_dev within ±0x0010_0000, o_lock=1.
REQ-031 Change the transmitter word to 0x0110_0000 -> o_dev=0x0010_0000 ±0x0010_0000 within two windows.
REQ-032 i_sig stuck at 0 -> o_word=0, o_dev=0-i_center (e.g. 0xFF00_0000 for center 0x0100_0000), o_lock=0, o_valid every 4096 cycles.
REQ-033 i_sig toggling every clock -> 2048 edges/window -> o_word=0x8000_0000.
REQ-034 Drop i_en mid-window -> no o_valid, o_lock=0 next cycle, o_word held; re-enable -> first o_valid after 8193 cycles.
REQ-035 Assert i_rst_n low mid-window -> all outputs 0 immediately, FSM IDLE, no o_valid for the interrupted window.
